id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Issue controller for the decode stage. It keeps a register scoreboard of writes in flight, decides each cycle whether the instruction held in ID may advance to EXE, and generates the IF/ID stall and flush controls. It also sequences the wrong-path squash window after a branch or jump redirect from EXE. It sits beside `id_stage`: it takes the decoded register fields and the writeback fields, and drives the pipeline-register enables and flushes.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles of forced ID squash after a redirect (range 1–15).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `id_valid` in 1: ID pipeline register holds a valid instruction.
- `id_rs1` in 5 / `id_rs1_used` in 1: source 1 index and use flag.
- `id_rs2` in 5 / `id_rs2_used` in 1: source 2 index and use flag.
- `id_rd` in 5 / `id_rd_wen` in 1: destination index and write-enable.
- `exe_ready` in 1: EXE accepts an instruction this cycle.
- `wb_we` in 1 / `wb_addr` in 5: writeback write-enable and address (the same fields as `wb_data_bus`).
- `redirect_valid` in 1: EXE resolved a taken branch or jump this cycle.
- `id_issue` out 1: the ID instruction moves to EXE at this edge.
- `id_stall` out 1: hold the ID register.
- `if_stall` out 1: hold the PC and the IF/ID register.
- `id_flush` out 1: load a bubble into the ID→EXE path.
- `if_flush` out 1: invalidate the IF/ID register.
- `busy_mask` out 32: scoreboard pending bits; bit 0 is always 0.
- `stall_cnt` out `CNT_W`: hazard-stall cycles, saturating.
- `flush_cnt` out `CNT_W`: squash cycles, saturating.

## Operation
- **Scoreboard.** `pending[31:1]` holds one bit per register. x0 is never pending.
- **Hazard.** `hazard` is the OR of:
  - `id_rs1_used & id_rs1!=0 & pending[id_rs1]`;
  - the same term for rs2;
  - `id_rd_wen & id_rd!=0 & pending[id_rd]` (WAW).
  
  Hazard is evaluated only on the registered `pending`. There is no writeback bypass: a register cleared this cycle still counts as pending this cycle.
- **FSM states.**
  - RUN: normal operation.
  - FLUSH: squash window of length `FLUSH_CYCLES`, timed by a down-counter `fcnt`.
- **Transitions.**
  - Any state, `redirect_valid` → FLUSH, with `fcnt = FLUSH_CYCLES-1`. A redirect during FLUSH restarts the window.
  - FLUSH with `fcnt==0` and no redirect → RUN. Otherwise `fcnt` decrements.
- **Issue.** `id_issue = state==RUN & !redirect_valid & id_valid & !hazard & exe_ready`.
- **Stall.** `id_stall = if_stall = state==RUN & !redirect_valid & id_valid & !id_issue`.
- **Flush.** `id_flush = if_flush = redirect_valid | state==FLUSH`. Stalls are 0 whenever flush is 1.
- **Scoreboard update at the clock edge.**
  - Set `pending[id_rd]` when `id_issue & id_rd_wen & id_rd!=0`.
  - Clear `pending[wb_addr]` when `wb_we & wb_addr!=0`.
  - If both target the same register in the same cycle, the set wins (the new writer owns the register).
- **Redirect does not clear `pending`.** Instructions older than the branch still write back. Squashed instructions never set bits.
- **Counters.**
  - `stall_cnt` increments on cycles with `id_stall` high.
  - `flush_cnt` increments on cycles with `id_flush` high.
  - Both hold at all-ones.

## Timing
- `id_issue`, stalls and flushes are combinational from the current inputs plus registered state: zero latency.
- A scoreboard set or clear is visible from the next cycle.
- For an instruction dependent on a producer issued at cycle t with writeback at cycle w, the dependent instruction issues no earlier than w+1.
- A redirect at cycle t asserts flush for cycles t … t+FLUSH_CYCLES. The earliest issue is cycle t+FLUSH_CYCLES+1.
- While `rst_n` is low at an edge:
  - `pending`, `fcnt` and the counters clear to 0, and the state goes to RUN.
  - All outputs are forced to 0 combinationally during the reset cycle, including mid-FLUSH.
- `exe_ready` low with no hazard: stall, no issue, no scoreboard set.

## Structure
- Shared pipeline package holds:
  - the FSM state enum (RUN, FLUSH);
  - the register index width constant (5) and register count (32);
  - the `wb_data_bus` field offsets, so this block and `id_stage` unpack the bus identically.
- One natural sub-module: `reg_scoreboard` (pending bits, set/clear priority, the two read ports and the WAW port).
- The FSM and counters stay in the top level.

## Test plan
- **RAW stall.** Issue `rd=5` at cycle 0. At cycle 1 present `rs1=5`. Writeback x5 at cycle 4. Required:
  - `id_stall`=1 on cycles 1–4;
  - `id_issue`=1 at cycle 5;
  - `stall_cnt`=4.
- **x0 is never a hazard.** Issue `rd=0`, then `rs1=rs2=0`, back-to-back. Required: no stall, `busy_mask`=0.
- **Set/clear collision.** `wb_we` with `wb_addr=7` in the same cycle as an issue with `rd=7`. Required: `busy_mask[7]`=1 next cycle. A later writeback of x7 clears it.
- **Redirect window.** `redirect_valid` at cycle 10 with `FLUSH_CYCLES=2` and an issuable ID instruction. Required:
  - `id_issue`=0 and flush=1 on cycles 10–12;
  - issue possible at cycle 13;
  - a second redirect at cycle 11 extends flush through cycle 13.
- **Backpressure.** `exe_ready`=0 for 3 cycles with no hazard. Required: stall for 3 cycles, no scoreboard change, then issue.
- **Reset mid-FLUSH.** Assert `rst_n`=0 during FLUSH with `pending`≠0. Required:
  - all outputs 0 in the reset cycle;
  - afterwards `busy_mask`=0, state RUN, counters 0.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode-stage definitions: issue FSM states, register-file geometry
// and the writeback bus layout used by both id_stage and id_hazard_ctrl.
package id_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned REG_COUNT = 32;

    // wb_data_bus layout: {we, addr[4:0], data[31:0]}
    localparam int unsigned WB_DATA_LSB = 0;
    localparam int unsigned WB_DATA_W   = 32;
    localparam int unsigned WB_ADDR_LSB = WB_DATA_LSB + WB_DATA_W;
    localparam int unsigned WB_WE_BIT   = WB_ADDR_LSB + REG_IDX_W;
    localparam int unsigned WB_BUS_W    = WB_WE_BIT + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    // One-hot register mask; x0 never produces a bit.
    function automatic logic [REG_COUNT-1:0] reg_onehot(
        input logic [REG_IDX_W-1:0] idx,
        input logic                 en
    );
        logic [REG_COUNT-1:0] mask;
        mask = '0;
        if (en && (idx != 5'd0)) begin
            mask[idx] = 1'b1;
        end else begin
            mask = '0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with an
// issue-side set, a writeback-side clear and three lookup ports.
module reg_scoreboard
    import id_hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set_en,
    input  logic [REG_IDX_W-1:0] i_set_addr,
    input  logic                 i_clr_en,
    input  logic [REG_IDX_W-1:0] i_clr_addr,
    input  logic [REG_IDX_W-1:0] i_rs1_addr,
    input  logic [REG_IDX_W-1:0] i_rs2_addr,
    input  logic [REG_IDX_W-1:0] i_rd_addr,
    output logic [REG_COUNT-1:0] o_pending,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy,
    output logic                 o_rd_busy
);

    logic [REG_COUNT-1:0] r_pending;
    logic [REG_COUNT-1:0] w_set_mask;
    logic [REG_COUNT-1:0] w_clr_mask;
    logic [REG_COUNT-1:0] w_pending_nxt;

    // Next pending state: clear first so a same-register set (new writer) wins.
    always_comb begin
        w_set_mask       = reg_onehot(i_set_addr, i_set_en);
        w_clr_mask       = reg_onehot(i_clr_addr, i_clr_en);
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Lookup ports read registered state only: no writeback bypass.
    always_comb begin
        o_pending  = r_pending;
        o_rs1_busy = r_pending[i_rs1_addr];
        o_rs2_busy = r_pending[i_rs2_addr];
        o_rd_busy  = r_pending[i_rd_addr];
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: RAW/WAW hazard detection against the
// scoreboard, IF/ID stall and flush generation, redirect squash window.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1,
    input  logic                 id_rs1_used,
    input  logic [4:0]           id_rs2,
    input  logic                 id_rs2_used,
    input  logic [4:0]           id_rd,
    input  logic                 id_rd_wen,
    input  logic                 exe_ready,
    input  logic                 wb_we,
    input  logic [4:0]           wb_addr,
    input  logic                 redirect_valid,
    output logic                 id_issue,
    output logic                 id_stall,
    output logic                 if_stall,
    output logic                 id_flush,
    output logic                 if_flush,
    output logic [31:0]          busy_mask,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [3:0]       FCNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e            r_state;
    logic [3:0]           r_fcnt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic [REG_COUNT-1:0] w_pending;
    logic                 w_rs1_busy;
    logic                 w_rs2_busy;
    logic                 w_rd_busy;
    logic                 w_hazard;
    logic                 w_run;
    logic                 w_issue;
    logic                 w_stall;
    logic                 w_flush;
    logic                 w_sb_set;
    logic                 w_sb_clr;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_sb_set),
        .i_set_addr (id_rd),
        .i_clr_en   (w_sb_clr),
        .i_clr_addr (wb_addr),
        .i_rs1_addr (id_rs1),
        .i_rs2_addr (id_rs2),
        .i_rd_addr  (id_rd),
        .o_pending  (w_pending),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy),
        .o_rd_busy  (w_rd_busy)
    );

    // Issue/stall/flush decision; everything is held at 0 while in reset.
    always_comb begin
        w_hazard = (id_rs1_used && (id_rs1 != 5'd0) && w_rs1_busy) ||
                   (id_rs2_used && (id_rs2 != 5'd0) && w_rs2_busy) ||
                   (id_rd_wen   && (id_rd  != 5'd0) && w_rd_busy);
        w_run    = (r_state == ST_RUN) && !redirect_valid;
        w_issue  = 1'b0;
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        if (rst_n) begin
            w_issue = w_run && id_valid && !w_hazard && exe_ready;
            w_stall = w_run && id_valid && !w_issue;
            w_flush = redirect_valid || (r_state == ST_FLUSH);
        end else begin
            w_issue = 1'b0;
            w_stall = 1'b0;
            w_flush = 1'b0;
        end
        w_sb_set = w_issue && id_rd_wen;
        w_sb_clr = wb_we;
    end

    // Output drive, forced low during reset.
    always_comb begin
        id_issue = w_issue;
        id_stall = w_stall;
        if_stall = w_stall;
        id_flush = w_flush;
        if_flush = w_flush;
        if (rst_n) begin
            busy_mask = w_pending;
            stall_cnt = r_stall_cnt;
            flush_cnt = r_flush_cnt;
        end else begin
            busy_mask = 32'h0000_0000;
            stall_cnt = '0;
            flush_cnt = '0;
        end
    end

    // Squash-window FSM; a redirect in any state (re)starts the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_fcnt  <= 4'd0;
        end else if (redirect_valid) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= FCNT_INIT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_fcnt  <= 4'd0;
                end
                ST_FLUSH: begin
                    if (r_fcnt == 4'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_fcnt  <= r_fcnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_fcnt  <= 4'd0;
                end
            endcase
        end
    end

    // Saturating stall and flush cycle counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: RAW/WAW stalls, x0, set/clear collision,
// redirect windows, backpressure and reset in the middle of a flush.
module tb_id_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_used;
    logic [4:0]  id_rs2;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_wen;
    logic        exe_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic        redirect_valid;
    logic        id_issue;
    logic        id_stall;
    logic        if_stall;
    logic        id_flush;
    logic        if_flush;
    logic [31:0] busy_mask;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_err;
    int n_checks;

    id_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs1_used    (id_rs1_used),
        .id_rs2         (id_rs2),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_rd_wen      (id_rd_wen),
        .exe_ready      (exe_ready),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .redirect_valid (redirect_valid),
        .id_issue       (id_issue),
        .id_stall       (id_stall),
        .if_stall       (if_stall),
        .id_flush       (id_flush),
        .if_flush       (if_flush),
        .busy_mask      (busy_mask),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic iss, input logic stl, input logic fl);
        chk({tag, ".id_issue"}, {63'd0, id_issue}, {63'd0, iss});
        chk({tag, ".id_stall"}, {63'd0, id_stall}, {63'd0, stl});
        chk({tag, ".if_stall"}, {63'd0, if_stall}, {63'd0, stl});
        chk({tag, ".id_flush"}, {63'd0, id_flush}, {63'd0, fl});
        chk({tag, ".if_flush"}, {63'd0, if_flush}, {63'd0, fl});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid       = 1'b0;
        id_rs1         = 5'd0;
        id_rs1_used    = 1'b0;
        id_rs2         = 5'd0;
        id_rs2_used    = 1'b0;
        id_rd          = 5'd0;
        id_rd_wen      = 1'b0;
        exe_ready      = 1'b1;
        wb_we          = 1'b0;
        wb_addr        = 5'd0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        idle_inputs();

        // Reset with an issuable instruction present: everything stays 0.
        next_cycle();
        id_valid = 1'b1;
        settle();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.busy", {32'd0, busy_mask}, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        chk_ctl("post_reset", 1'b0, 1'b0, 1'b0);
        chk("post_reset.stall_cnt", {32'd0, stall_cnt}, 64'd0);
        chk("post_reset.flush_cnt", {32'd0, flush_cnt}, 64'd0);

        // RAW: producer rd=5 at cycle 0, consumer rs1=5, writeback at cycle 4.
        next_cycle();
        id_valid = 1'b1; id_rd = 5'd5; id_rd_wen = 1'b1;
        settle();
        chk_ctl("raw.c0", 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            idle_inputs();
            id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
            if (c == 4) begin
                wb_we = 1'b1; wb_addr = 5'd5;
            end else begin
                wb_we = 1'b0;
            end
            settle();
            chk_ctl($sformatf("raw.c%0d", c), 1'b0, 1'b1, 1'b0);
            chk($sformatf("raw.busy.c%0d", c), {32'd0, busy_mask}, 64'h20);
        end
        next_cycle();
        wb_we = 1'b0;
        settle();
        chk_ctl("raw.c5", 1'b1, 1'b0, 1'b0);
        chk("raw.c5.busy", {32'd0, busy_mask}, 64'd0);
        chk("raw.c5.stall_cnt", {32'd0, stall_cnt}, 64'd4);

        // x0 is never a hazard.
        next_cycle();
        idle_inputs();
        id_valid = 1'b1; id_rd = 5'd0; id_rd_wen = 1'b1;
        settle();
        chk_ctl("x0.wr", 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle_inputs();
        id_valid = 1'b1; id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_wen = 1'b1;
        settle();
        chk_ctl("x0.rd", 1'b1, 1'b0, 1'b0);
        chk("x0.busy", {32'd0, busy_mask}, 64'd0);

        // Set/clear collision on x7: the set wins.
        next_cycle();
        idle_inputs();
        id_valid = 1'b1; id_rd = 5'd7; id_rd_wen = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd7;
        settle();
        chk_ctl("coll.issue", 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle_inputs();
        id_valid = 1'b1; id_rd = 5'd7; id_rd_wen = 1'b1;
        settle();
        chk("coll.busy", {32'd0, busy_mask}, 64'h80);
        chk_ctl("coll.waw", 1'b0, 1'b1, 1'b0);
        next_cycle();
        idle_inputs();
        id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd7;
        settle();
        chk_ctl("coll.no_bypass", 1'b0, 1'b1, 1'b0);
        next_cycle();
        wb_we = 1'b0;
        settle();
        chk("coll.cleared", {32'd0, busy_mask}, 64'd0);
        chk_ctl("coll.rs2_issue", 1'b1, 1'b0, 1'b0);
        chk("coll.stall_cnt", {32'd0, stall_cnt}, 64'd6);

        // Backpressure: 3 cycles of exe_ready=0, no scoreboard set meanwhile.
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            idle_inputs();
            id_valid = 1'b1; id_rd = 5'd9; id_rd_wen = 1'b1; exe_ready = 1'b0;
            settle();
            chk_ctl($sformatf("bp.c%0d", c), 1'b0, 1'b1, 1'b0);
            chk($sformatf("bp.busy.c%0d", c), {32'd0, busy_mask}, 64'd0);
        end
        next_cycle();
        exe_ready = 1'b1;
        settle();
        chk_ctl("bp.issue", 1'b1, 1'b0, 1'b0);
        chk("bp.stall_cnt", {32'd0, stall_cnt}, 64'd9);
        next_cycle();
        idle_inputs();
        settle();
        chk("bp.busy_after", {32'd0, busy_mask}, 64'h200);

        // Single redirect with an issuable instruction waiting.
        next_cycle();
        idle_inputs();
        id_valid = 1'b1; redirect_valid = 1'b1;
        settle();
        chk_ctl("redir.t0", 1'b0, 1'b0, 1'b1);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        chk_ctl("redir.t1", 1'b0, 1'b0, 1'b1);
        next_cycle();
        settle();
        chk_ctl("redir.t2", 1'b0, 1'b0, 1'b1);
        next_cycle();
        settle();
        chk_ctl("redir.t3", 1'b1, 1'b0, 1'b0);
        chk("redir.flush_cnt", {32'd0, flush_cnt}, 64'd3);
        chk("redir.busy_kept", {32'd0, busy_mask}, 64'h200);

        // Second redirect one cycle later extends the window by one.
        next_cycle();
        redirect_valid = 1'b1;
        settle();
        chk_ctl("redir2.t0", 1'b0, 1'b0, 1'b1);
        next_cycle();
        redirect_valid = 1'b1;
        settle();
        chk_ctl("redir2.t1", 1'b0, 1'b0, 1'b1);
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            redirect_valid = 1'b0;
            settle();
            chk_ctl($sformatf("redir2.t%0d", c), 1'b0, 1'b0, 1'b1);
        end
        next_cycle();
        settle();
        chk_ctl("redir2.t4", 1'b1, 1'b0, 1'b0);
        chk("redir2.flush_cnt", {32'd0, flush_cnt}, 64'd7);

        // Reset in the middle of a flush window with x9 still pending.
        next_cycle();
        idle_inputs();
        redirect_valid = 1'b1;
        settle();
        chk("rstf.busy_before", {32'd0, busy_mask}, 64'h200);
        next_cycle();
        idle_inputs();
        rst_n = 1'b0; id_valid = 1'b1;
        settle();
        chk_ctl("rstf.in_reset", 1'b0, 1'b0, 1'b0);
        chk("rstf.busy_in_reset", {32'd0, busy_mask}, 64'd0);
        chk("rstf.stall_cnt_in_reset", {32'd0, stall_cnt}, 64'd0);
        chk("rstf.flush_cnt_in_reset", {32'd0, flush_cnt}, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        settle();
        chk_ctl("rstf.after", 1'b1, 1'b0, 1'b0);
        chk("rstf.busy_after", {32'd0, busy_mask}, 64'd0);
        chk("rstf.stall_cnt_after", {32'd0, stall_cnt}, 64'd0);
        chk("rstf.flush_cnt_after", {32'd0, flush_cnt}, 64'd0);

        next_cycle();
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
